apb_wait_ram: RTL and testbench

APB3/APB4 completer backed by a word-addressed on-chip RAM with a fixed, parameterised number of wait states. It is the far end of the APB chain: it terminates transfers issued by an APB initiator, or by the cycle-scaling APB delayer placed in front of it, and gives the SoC a deterministic-latency memory target for bus and delay-model bring-up. It checks address range, alignment and handshake sequencing, and reports protocol misuse on a sticky flag.

---
 rtl/apb_wait_ram_if.sv | 24 ++
 rtl/apb_wait_ram.sv | 136 +++++++++++++
 tb/tb_apb_wait_ram.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_wait_ram_if.sv
// APB3/APB4 bus bundle between an initiator and apb_wait_ram.
// Carries the request, handshake and response signals of one completer port.
interface apb_wait_ram_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_wait_ram.sv
// APB completer backed by a word RAM with a fixed number of wait states.
// Latches the request in setup, counts waits, and flags protocol misuse.
module apb_wait_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'h0f00_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    apb_wait_ram_if.slave apb,
    output logic          proto_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [32:0] LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI = LO + 33'(4 * DEPTH_WORDS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          proto_q, proto_d;

    logic [AW-1:0] idx_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic [3:0]    strb_q;
    logic          err_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [32:0]   addr33;
    logic [31:0]   offs;
    logic [AW-1:0] idx;
    logic          addr_err;
    logic          capture;
    logic          commit;
    logic          pready;
    logic          pslverr;
    logic          unused;

    assign addr33   = {1'b0, apb.paddr};
    assign offs     = apb.paddr - BASE_ADDR;
    assign idx      = offs[AW+1:2];
    assign addr_err = (addr33 < LO) || (addr33 >= HI)
                   || (apb.paddr[1:0] != 2'b00);
    assign unused   = ^{apb.pprot, offs[31:AW+2], offs[1:0]};

    // State, wait counter and sticky violation flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            proto_q <= proto_d;
        end
    end

    // Next-state, handshake response and capture/commit strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        proto_d = proto_q;
        capture = 1'b0;
        commit  = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (apb.penable) begin
                    proto_d = 1'b1;
                end else if (apb.psel) begin
                    capture = 1'b1;
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!(apb.psel && apb.penable)) begin
                    proto_d = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    pready  = 1'b1;
                    pslverr = err_q;
                    commit  = write_q && !err_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch and RAM read taken on the setup edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (capture) begin
            idx_q   <= idx;
            write_q <= apb.pwrite;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
            err_q   <= addr_err;
            rdata_q <= addr_err ? 32'h0 : mem[idx];
        end
    end

    // Byte-lane write on the completing edge of an error-free write.
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign apb.pready  = pready;
    assign apb.pslverr = pslverr;
    assign apb.prdata  = (pready && !write_q && !err_q) ? rdata_q : 32'h0;
    assign proto_err   = proto_q;
endmodule

// File: tb/tb_apb_wait_ram.sv
// Directed bench for apb_wait_ram: one instance with two wait states,
// one with none for back-to-back traffic.
module tb_apb_wait_ram;
    logic clk = 1'b0;
    logic rst2_n = 1'b0;
    logic rst0_n = 1'b0;
    logic perr2, perr0;

    logic        sel = 1'b0;
    logic [31:0] paddr_v = '0;
    logic        psel_v = 1'b0;
    logic        penable_v = 1'b0;
    logic        pwrite_v = 1'b0;
    logic [31:0] pwdata_v = '0;
    logic [3:0]  pstrb_v = '0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    apb_wait_ram_if bus2 ();
    apb_wait_ram_if bus0 ();

    assign bus2.paddr   = paddr_v;
    assign bus2.psel    = psel_v && !sel;
    assign bus2.penable = penable_v && !sel;
    assign bus2.pprot   = 3'b000;
    assign bus2.pwrite  = pwrite_v;
    assign bus2.pwdata  = pwdata_v;
    assign bus2.pstrb   = pstrb_v;

    assign bus0.paddr   = paddr_v;
    assign bus0.psel    = psel_v && sel;
    assign bus0.penable = penable_v && sel;
    assign bus0.pprot   = 3'b010;
    assign bus0.pwrite  = pwrite_v;
    assign bus0.pwdata  = pwdata_v;
    assign bus0.pstrb   = pstrb_v;

    wire        pready_m  = sel ? bus0.pready  : bus2.pready;
    wire [31:0] prdata_m  = sel ? bus0.prdata  : bus2.prdata;
    wire        pslverr_m = sel ? bus0.pslverr : bus2.pslverr;

    apb_wait_ram #(
        .BASE_ADDR  (32'h0f00_0000),
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(2)
    ) dut2 (
        .clock    (clk),
        .reset_n  (rst2_n),
        .apb      (bus2),
        .proto_err(perr2)
    );

    apb_wait_ram #(
        .BASE_ADDR  (32'h0f00_0000),
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(0)
    ) dut0 (
        .clock    (clk),
        .reset_n  (rst0_n),
        .apb      (bus0),
        .proto_err(perr0)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] er;
        logic        ee;
        int          ec;
    } vec_t;

    vec_t v2[15];
    vec_t v0[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Starts at posedge+1, ends at posedge+1 after completion so that
    // consecutive calls present setup right after pready.
    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er,
                        output int n);
        bit done;
        paddr_v   = a;
        pwrite_v  = w;
        pwdata_v  = d;
        pstrb_v   = s;
        psel_v    = 1'b1;
        penable_v = 1'b0;
        @(posedge clk); #1;
        penable_v = 1'b1;
        paddr_v   = ~a;
        pwdata_v  = ~d;
        pstrb_v   = ~s;
        n = 0; rd = '0; er = 1'b0; done = 1'b0;
        while (!done && n < 16) begin
            @(negedge clk);
            n++;
            if (pready_m) begin
                rd   = prdata_m;
                er   = pslverr_m;
                done = 1'b1;
            end else begin
                chk("wait_prdata", prdata_m, 32'h0);
                chk("wait_pslverr", {31'b0, pslverr_m}, 32'h0);
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL timeout: no pready after %0d cycles", n);
        end
        psel_v    = 1'b0;
        penable_v = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [31:0] rd;
        logic        er;
        int          n;
        xfer(v.w, v.a, v.d, v.s, rd, er, n);
        chk({tag, "_rdata"}, rd, v.er);
        chk({tag, "_pslverr"}, {31'b0, er}, {31'b0, v.ee});
        chk({tag, "_cycles"}, n, v.ec);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;

        v2[0]  = '{1'b1, 32'h0f00_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 3};
        v2[1]  = '{1'b0, 32'h0f00_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3};
        v2[2]  = '{1'b1, 32'h0f00_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 3};
        v2[3]  = '{1'b1, 32'h0f00_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0, 3};
        v2[4]  = '{1'b0, 32'h0f00_0020, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 3};
        v2[5]  = '{1'b1, 32'h0f00_0ffc, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 3};
        v2[6]  = '{1'b1, 32'h0f00_0000, 32'h600D_F00D, 4'hF, 32'h0, 1'b0, 3};
        v2[7]  = '{1'b0, 32'h0f00_1000, 32'h0, 4'h0, 32'h0, 1'b1, 3};
        v2[8]  = '{1'b1, 32'h0f00_1000, 32'hBAD0_BAD0, 4'hF, 32'h0, 1'b1, 3};
        v2[9]  = '{1'b0, 32'h0f00_0002, 32'h0, 4'h0, 32'h0, 1'b1, 3};
        v2[10] = '{1'b1, 32'h0eff_fffc, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 3};
        v2[11] = '{1'b0, 32'h0f00_0ffc, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 3};
        v2[12] = '{1'b0, 32'h0f00_0000, 32'h0, 4'h0, 32'h600D_F00D, 1'b0, 3};
        v2[13] = '{1'b1, 32'h0f00_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 3};
        v2[14] = '{1'b0, 32'h0f00_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3};

        v0[0] = '{1'b1, 32'h0f00_0100, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, 1};
        v0[1] = '{1'b1, 32'h0f00_0104, 32'hA5A5_0002, 4'hF, 32'h0, 1'b0, 1};
        v0[2] = '{1'b1, 32'h0f00_0108, 32'hA5A5_0003, 4'hF, 32'h0, 1'b0, 1};
        v0[3] = '{1'b1, 32'h0f00_0104, 32'h5A00_0000, 4'h8, 32'h0, 1'b0, 1};
        v0[4] = '{1'b0, 32'h0f00_0100, 32'h0, 4'h0, 32'hA5A5_0001, 1'b0, 1};
        v0[5] = '{1'b0, 32'h0f00_0104, 32'h0, 4'h0, 32'h5AA5_0002, 1'b0, 1};
        v0[6] = '{1'b0, 32'h0f00_0108, 32'h0, 4'h0, 32'hA5A5_0003, 1'b0, 1};
        v0[7] = '{1'b0, 32'h0f00_0ffe, 32'h0, 4'h0, 32'h0, 1'b1, 1};

        #3;
        chk("rst_pready2", {31'b0, bus2.pready}, 32'h0);
        chk("rst_prdata2", bus2.prdata, 32'h0);
        chk("rst_pslverr2", {31'b0, bus2.pslverr}, 32'h0);
        chk("rst_proto2", {31'b0, perr2}, 32'h0);
        chk("rst_pready0", {31'b0, bus0.pready}, 32'h0);
        chk("rst_proto0", {31'b0, perr0}, 32'h0);
        @(posedge clk); #1;
        rst2_n = 1'b1;
        rst0_n = 1'b1;

        sel = 1'b0;
        for (int i = 0; i < 15; i++) run_vec($sformatf("w2v%0d", i), v2[i]);

        sel = 1'b1;
        for (int i = 0; i < 8; i++) run_vec($sformatf("b2b%0d", i), v0[i]);
        chk("b2b_proto", {31'b0, perr0}, 32'h0);

        // Access phase without setup while idle.
        sel = 1'b0;
        psel_v = 1'b1;
        penable_v = 1'b1;
        @(negedge clk);
        chk("nosetup_pready", {31'b0, pready_m}, 32'h0);
        @(posedge clk); #1;
        chk("nosetup_proto", {31'b0, perr2}, 32'h1);
        psel_v = 1'b0;
        penable_v = 1'b0;
        @(posedge clk); #1;
        chk("nosetup_sticky", {31'b0, perr2}, 32'h1);
        rst2_n = 1'b0;
        #1;
        chk("proto_clear", {31'b0, perr2}, 32'h0);
        @(posedge clk); #1;
        rst2_n = 1'b1;

        // Select dropped while a write is waiting.
        xfer(1'b1, 32'h0f00_0030, 32'h0101_0101, 4'hF, rd, er, n);
        chk("abort_pre_cycles", n, 3);
        paddr_v = 32'h0f00_0030;
        pwrite_v = 1'b1;
        pwdata_v = 32'hFFFF_FFFF;
        pstrb_v = 4'hF;
        psel_v = 1'b1;
        penable_v = 1'b0;
        @(posedge clk); #1;
        penable_v = 1'b1;
        @(posedge clk); #1;
        psel_v = 1'b0;
        penable_v = 1'b0;
        @(negedge clk);
        chk("abort_pready", {31'b0, pready_m}, 32'h0);
        @(posedge clk); #1;
        chk("abort_proto", {31'b0, perr2}, 32'h1);
        run_vec("abort_rd", '{1'b0, 32'h0f00_0030, 32'h0, 4'h0,
                              32'h0101_0101, 1'b0, 3});

        // Reset during the first wait cycle of a write.
        xfer(1'b1, 32'h0f00_0040, 32'h55AA_55AA, 4'hF, rd, er, n);
        chk("rstmid_pre_err", {31'b0, er}, 32'h0);
        paddr_v = 32'h0f00_0040;
        pwrite_v = 1'b1;
        pwdata_v = 32'h0000_0000;
        pstrb_v = 4'hF;
        psel_v = 1'b1;
        penable_v = 1'b0;
        @(posedge clk); #1;
        penable_v = 1'b1;
        @(negedge clk);
        rst2_n = 1'b0;
        #1;
        chk("rstmid_pready", {31'b0, pready_m}, 32'h0);
        chk("rstmid_pslverr", {31'b0, pslverr_m}, 32'h0);
        chk("rstmid_prdata", prdata_m, 32'h0);
        chk("rstmid_proto", {31'b0, perr2}, 32'h0);
        @(posedge clk); #1;
        chk("rstmid_held", {31'b0, pready_m}, 32'h0);
        psel_v = 1'b0;
        penable_v = 1'b0;
        rst2_n = 1'b1;
        run_vec("rstmid_rd", '{1'b0, 32'h0f00_0040, 32'h0, 4'h0,
                               32'h55AA_55AA, 1'b0, 3});
        chk("final_proto", {31'b0, perr2}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
